// File: rtl/instr_encoder.sv
// Instruction encoder: turns R-type / addi / nop requests into 32-bit MIPS
// words and streams them into instruction memory at consecutive word
// addresses starting at BASE_ADDR. Used by the boot/test path to preload imem.
module instr_encoder #(
    parameter int          ADDR_W    = 8,
    parameter logic [31:0] BASE_ADDR = 32'h0000_0000
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              start_i,
    input  logic              valid_i,
    output logic              ready_o,
    input  logic [1:0]        kind_i,
    input  logic              last_i,
    input  logic [4:0]        rs_i,
    input  logic [4:0]        rt_i,
    input  logic [4:0]        rd_i,
    input  logic [5:0]        funct_i,
    input  logic [15:0]       imm_i,
    output logic              mem_we_o,
    output logic [31:0]       mem_addr_o,
    output logic [31:0]       mem_data_o,
    output logic [ADDR_W:0]   count_o,
    output logic              full_o,
    output logic              done_o,
    output logic              err_o
);

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_RUN  = 2'd1;
    localparam logic [1:0] ST_DONE = 2'd2;

    localparam logic [1:0] KIND_RTYPE = 2'b00;
    localparam logic [1:0] KIND_ADDI  = 2'b01;
    localparam logic [1:0] KIND_NOP   = 2'b10;

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_ADDI  = 6'b001000;

    // Count value meaning "every imem slot has been written" (DEPTH).
    localparam logic [ADDR_W:0] CNT_FULL = {1'b1, {ADDR_W{1'b0}}};
    localparam logic [ADDR_W:0] CNT_ONE  = 1;

    logic [1:0]      state_q, state_d;
    logic [ADDR_W:0] count_q, count_d;
    logic            err_q, err_d;
    logic            we_q, we_d;
    logic [31:0]     addr_q, addr_d;
    logic [31:0]     data_q, data_d;
    logic            done_q, done_d;

    logic            full;
    logic            accept;
    logic            reserved;
    logic [31:0]     enc_word;

    assign full     = (count_q == CNT_FULL);
    assign ready_o  = (state_q == ST_RUN) && !full && !start_i;
    assign accept   = valid_i && ready_o;
    assign reserved = (kind_i == 2'b11);

    // Build the instruction word for the current request.
    always_comb begin
        enc_word = 32'h0000_0000;
        case (kind_i)
            KIND_RTYPE: enc_word = {OP_RTYPE, rs_i, rt_i, rd_i, 5'b00000, funct_i};
            KIND_ADDI:  enc_word = {OP_ADDI, rs_i, rt_i, imm_i};
            KIND_NOP:   enc_word = 32'h0000_0000;
            default:    enc_word = 32'h0000_0000;
        endcase
    end

    // Next-state logic: start overrides everything; otherwise handle an accept.
    always_comb begin
        state_d = state_q;
        count_d = count_q;
        err_d   = err_q;
        we_d    = 1'b0;
        addr_d  = addr_q;
        data_d  = data_q;
        done_d  = 1'b0;

        if (start_i) begin
            // Restart: clear progress and begin addressing at BASE_ADDR again.
            state_d = ST_RUN;
            count_d = '0;
            err_d   = 1'b0;
        end else if (accept) begin
            if (reserved) begin
                // Reserved kind consumes the handshake but writes nothing.
                err_d = 1'b1;
            end else begin
                we_d    = 1'b1;
                data_d  = enc_word;
                addr_d  = BASE_ADDR + (32'(count_q) << 2);
                count_d = count_q + CNT_ONE;
            end
            if (last_i) begin
                state_d = ST_DONE;
                done_d  = 1'b1;
            end
        end
    end

    // State and output registers with synchronous reset.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q <= ST_IDLE;
            count_q <= '0;
            err_q   <= 1'b0;
            we_q    <= 1'b0;
            addr_q  <= 32'h0000_0000;
            data_q  <= 32'h0000_0000;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            count_q <= count_d;
            err_q   <= err_d;
            we_q    <= we_d;
            addr_q  <= addr_d;
            data_q  <= data_d;
            done_q  <= done_d;
        end
    end

    assign mem_we_o   = we_q;
    assign mem_addr_o = addr_q;
    assign mem_data_o = data_q;
    assign count_o    = count_q;
    assign full_o     = full;
    assign done_o     = done_q;
    assign err_o      = err_q;

endmodule

// File: tb/tb_instr_encoder.sv
// Bench for instr_encoder: two instances (ADDR_W=8 and ADDR_W=2) share one
// stimulus stream and are compared every cycle against a behavioural model.
module tb_instr_encoder;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst, start, valid, last;
    logic [1:0]  kind;
    logic [4:0]  rs, rt, rd;
    logic [5:0]  funct;
    logic [15:0] imm;

    logic        ready_w [2];
    logic        we_w    [2];
    logic [31:0] addr_w  [2];
    logic [31:0] data_w  [2];
    logic        full_w  [2];
    logic        done_w  [2];
    logic        err_w   [2];
    logic [8:0]  cnt0;
    logic [2:0]  cnt1;

    instr_encoder #(.ADDR_W(8), .BASE_ADDR(32'h0000_0000)) dut0 (
        .clk_i(clk), .rst_i(rst), .start_i(start), .valid_i(valid),
        .ready_o(ready_w[0]), .kind_i(kind), .last_i(last),
        .rs_i(rs), .rt_i(rt), .rd_i(rd), .funct_i(funct), .imm_i(imm),
        .mem_we_o(we_w[0]), .mem_addr_o(addr_w[0]), .mem_data_o(data_w[0]),
        .count_o(cnt0), .full_o(full_w[0]), .done_o(done_w[0]), .err_o(err_w[0])
    );

    instr_encoder #(.ADDR_W(2), .BASE_ADDR(32'h0000_0000)) dut1 (
        .clk_i(clk), .rst_i(rst), .start_i(start), .valid_i(valid),
        .ready_o(ready_w[1]), .kind_i(kind), .last_i(last),
        .rs_i(rs), .rt_i(rt), .rd_i(rd), .funct_i(funct), .imm_i(imm),
        .mem_we_o(we_w[1]), .mem_addr_o(addr_w[1]), .mem_data_o(data_w[1]),
        .count_o(cnt1), .full_o(full_w[1]), .done_o(done_w[1]), .err_o(err_w[1])
    );

    int n_checks = 0;
    int n_pass   = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s got=0x%08h exp=0x%08h @%0t", tag, got, exp, $time);
    endtask

    // Behavioural model: per instance, capacity, running flag and outputs.
    int          m_depth [2] = '{256, 4};
    bit          m_run   [2];
    int          m_cnt   [2];
    bit          m_err   [2];
    bit          m_we    [2];
    bit          m_done  [2];
    logic [31:0] m_addr  [2];
    logic [31:0] m_data  [2];

    function automatic logic [31:0] ref_word();
        logic [31:0] w;
        case (kind)
            2'd0: w = (32'(rs) << 21) | (32'(rt) << 16) | (32'(rd) << 11) | 32'(funct);
            2'd1: w = (32'd8 << 26) | (32'(rs) << 21) | (32'(rt) << 16) | 32'(imm);
            default: w = 32'd0;
        endcase
        return w;
    endfunction

    function automatic bit m_ready(int k);
        return m_run[k] && (m_cnt[k] < m_depth[k]) && !start;
    endfunction

    task automatic model_step();
        for (int k = 0; k < 2; k++) begin
            bit acc;
            acc = valid && m_ready(k);
            m_we[k]   = 1'b0;
            m_done[k] = 1'b0;
            if (rst) begin
                m_run[k] = 1'b0; m_cnt[k] = 0; m_err[k] = 1'b0;
                m_addr[k] = 32'd0; m_data[k] = 32'd0;
            end else if (start) begin
                m_run[k] = 1'b1; m_cnt[k] = 0; m_err[k] = 1'b0;
            end else if (acc) begin
                if (k == 0)
                    $display("txn kind=%0d last=%0d rs=%0d rt=%0d rd=%0d funct=0x%02h imm=0x%04h word=0x%08h",
                             kind, last, rs, rt, rd, funct, imm, ref_word());
                if (kind == 2'd3) m_err[k] = 1'b1;
                else begin
                    m_we[k]   = 1'b1;
                    m_data[k] = ref_word();
                    m_addr[k] = 32'd4 * 32'(m_cnt[k]);
                    m_cnt[k]  = m_cnt[k] + 1;
                end
                if (last) begin
                    m_done[k] = 1'b1;
                    m_run[k]  = 1'b0;
                end
            end
        end
    endtask

    task automatic check_outputs();
        for (int k = 0; k < 2; k++) begin
            logic [31:0] c;
            c = (k == 0) ? 32'(cnt0) : 32'(cnt1);
            chk($sformatf("u%0d_we", k),   32'(we_w[k]),   32'(m_we[k]));
            chk($sformatf("u%0d_cnt", k),  c,              32'(m_cnt[k]));
            chk($sformatf("u%0d_full", k), 32'(full_w[k]), 32'(m_cnt[k] == m_depth[k]));
            chk($sformatf("u%0d_done", k), 32'(done_w[k]), 32'(m_done[k]));
            chk($sformatf("u%0d_err", k),  32'(err_w[k]),  32'(m_err[k]));
            chk($sformatf("u%0d_addr", k), addr_w[k],      m_addr[k]);
            chk($sformatf("u%0d_data", k), data_w[k],      m_data[k]);
        end
    endtask

    // One clock: check combinational ready, clock, update model, check registers.
    task automatic cycle();
        #1;
        for (int k = 0; k < 2; k++)
            chk($sformatf("u%0d_ready", k), 32'(ready_w[k]), 32'(m_ready(k)));
        @(posedge clk);
        model_step();
        #1;
        check_outputs();
    endtask

    task automatic drive(input bit r, input bit st, input bit v, input logic [1:0] kd, input bit l,
                         input logic [4:0] a, input logic [4:0] b, input logic [4:0] c,
                         input logic [5:0] f, input logic [15:0] im);
        rst = r; start = st; valid = v; kind = kd; last = l;
        rs = a; rt = b; rd = c; funct = f; imm = im;
        cycle();
    endtask

    task automatic idle();
        drive(0, 0, 0, 2'd2, 0, 0, 0, 0, 0, 0);
    endtask

    task automatic nop(input bit l);
        drive(0, 0, 1, 2'd2, l, 0, 0, 0, 0, 0);
    endtask

    initial begin
        for (int k = 0; k < 2; k++) begin
            m_run[k] = 0; m_cnt[k] = 0; m_err[k] = 0; m_we[k] = 0; m_done[k] = 0;
            m_addr[k] = 0; m_data[k] = 0;
        end
        rst = 1; start = 0; valid = 0; kind = 0; last = 0;
        rs = 0; rt = 0; rd = 0; funct = 0; imm = 0;
        @(posedge clk);
        #1;

        // Reset, then idle with valid high: nothing accepted before start.
        drive(1, 0, 0, 2'd0, 0, 0, 0, 0, 0, 0);
        drive(1, 0, 0, 2'd0, 0, 0, 0, 0, 0, 0);
        drive(0, 0, 1, 2'd0, 0, 1, 2, 3, 6'h20, 0);
        chk("idle_cnt", 32'(cnt0), 32'd0);

        // Start, R-type, addi, nop back to back.
        drive(0, 1, 0, 2'd0, 0, 0, 0, 0, 0, 0);
        drive(0, 0, 1, 2'd0, 0, 1, 2, 3, 6'h20, 16'h0);
        chk("rtype_data", data_w[0], 32'h0022_1820);
        chk("rtype_addr", addr_w[0], 32'h0);
        chk("rtype_cnt", 32'(cnt0), 32'd1);
        drive(0, 0, 1, 2'd1, 0, 0, 8, 0, 0, 16'h0005);
        chk("addi_data", data_w[0], 32'h2008_0005);
        chk("addi_addr", addr_w[0], 32'h4);
        nop(0);
        chk("nop_data", data_w[0], 32'h0);
        chk("nop_addr", addr_w[0], 32'h8);
        chk("nop_cnt", 32'(cnt0), 32'd3);
        idle();

        // Fill the ADDR_W=2 instance: 5 nops, only 4 land.
        drive(0, 1, 0, 2'd0, 0, 0, 0, 0, 0, 0);
        for (int i = 0; i < 5; i++) nop(0);
        chk("full_cnt", 32'(cnt1), 32'd4);
        chk("full_flag", 32'(full_w[1]), 32'd1);
        chk("full_last_addr", addr_w[1], 32'hC);
        idle();

        // Reserved kind mid-stream.
        nop(0);
        drive(0, 0, 1, 2'd3, 0, 1, 1, 1, 1, 1);
        chk("rsv_we", 32'(we_w[0]), 32'd0);
        chk("rsv_err", 32'(err_w[0]), 32'd1);
        nop(0);
        idle();
        drive(0, 1, 0, 2'd0, 0, 0, 0, 0, 0, 0);
        chk("rsv_err_clr", 32'(err_w[0]), 32'd0);

        // addi with last: write and done pulse, then ignored until restart.
        nop(0);
        drive(0, 0, 1, 2'd1, 1, 3, 4, 0, 0, 16'hBEEF);
        chk("last_done", 32'(done_w[0]), 32'd1);
        chk("last_we", 32'(we_w[0]), 32'd1);
        chk("last_data", data_w[0], 32'h2064_BEEF);
        nop(0);
        nop(0);
        drive(0, 1, 0, 2'd0, 0, 0, 0, 0, 0, 0);
        nop(0);
        chk("restart_addr", addr_w[0], 32'h0);

        // Reserved kind as last: done without a write.
        drive(0, 0, 1, 2'd3, 1, 0, 0, 0, 0, 0);
        idle();

        // Reset right after an accept drops the write.
        drive(0, 1, 0, 2'd0, 0, 0, 0, 0, 0, 0);
        nop(0);
        drive(1, 0, 1, 2'd2, 0, 0, 0, 0, 0, 0);
        chk("rst_we", 32'(we_w[0]), 32'd0);
        idle();

        // start together with valid: no accept.
        drive(0, 1, 0, 2'd0, 0, 0, 0, 0, 0, 0);
        drive(0, 1, 1, 2'd0, 0, 1, 2, 3, 4, 0);
        chk("stv_cnt", 32'(cnt0), 32'd0);
        chk("stv_we", 32'(we_w[0]), 32'd0);

        // Randomised traffic.
        for (int i = 0; i < 400; i++) begin
            bit rr, ss, vv, ll;
            rr = ($urandom_range(0, 99) < 2);
            ss = ($urandom_range(0, 99) < 6);
            vv = ($urandom_range(0, 99) < 65);
            ll = ($urandom_range(0, 99) < 5);
            drive(rr, ss, vv, 2'($urandom_range(0, 3)), ll,
                  5'($urandom), 5'($urandom), 5'($urandom), 6'($urandom), 16'($urandom));
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/instr_encoder.md
Name: instr_encoder

Overview:
- Encodes instruction requests (R-type, addi, nop) into 32-bit MIPS words.
- Writes each word into instruction memory at consecutive word addresses.
- It is the encoder counterpart of the opcode decoder. It produces the exact opcode fields the decoder consumes (000000 for R-type, 001000 for addi).
- Used by the test/boot path to load programs into imem before the core runs.

Parameters:
- ADDR_W, 8, log2 of the number of instruction words that can be loaded (DEPTH = 2^ADDR_W).
- BASE_ADDR, 32'h0000_0000, byte address of the first written word.

Ports:
- clk_i  in  1  clock
- rst_i  in  1  reset, synchronous, active-high
- start_i  in  1  begin a new load: clear count/err, enter RUN
- valid_i  in  1  request valid
- ready_o  out  1  encoder can accept a request this cycle
- kind_i  in  2  00 R-type, 01 addi, 10 nop, 11 reserved
- last_i  in  1  request is the final one of the program
- rs_i  in  5  source register
- rt_i  in  5  target register
- rd_i  in  5  destination register (R-type only)
- funct_i  in  6  function field (R-type only)
- imm_i  in  16  immediate (addi only)
- mem_we_o  out  1  imem write strobe
- mem_addr_o  out  32  imem byte address
- mem_data_o  out  32  imem write data
- count_o  out  ADDR_W+1  words written since start
- full_o  out  1  count_o == DEPTH
- done_o  out  1  one-cycle pulse after the last_i word is written
- err_o  out  1  sticky: a reserved kind was accepted

Behaviour:
- Clock and reset: single clock clk_i; rst_i is synchronous, active-high.
- Reset values: all outputs 0; state IDLE; any pending write is dropped (no mem_we_o the cycle after reset).
- States:
  - IDLE: after reset.
  - RUN: accepting requests.
  - DONE: after the last_i word is accepted.
- Transitions:
  - IDLE/RUN/DONE -> RUN on start_i. start_i clears count_o, full_o and err_o.
  - RUN -> DONE on an accepted request with last_i=1.
- ready_o = (state==RUN) & !full_o & !start_i. It is combinational from registered state, plus start_i.
- Accept = valid_i & ready_o. If valid_i is high while ready_o is low, there is no effect; the requester holds its request.
- Encoding:
  - R-type: {6'b000000, rs, rt, rd, 5'b00000, funct}
  - addi: {6'b001000, rs, rt, imm}
  - nop: 32'h0000_0000
- Latency: when a request is accepted at edge N, in the cycle following edge N:
  - mem_we_o=1 for exactly one cycle;
  - mem_data_o = encoded word;
  - mem_addr_o = BASE_ADDR + 4*count_old (32-bit, wraps modulo 2^32);
  - count_o = count_old+1.
- mem_addr_o and mem_data_o hold their last values while mem_we_o=0.
- Back-to-back accepts every cycle are allowed, giving one write per cycle.
- Reserved kind (11):
  - the request is accepted (consumes the handshake);
  - no write occurs and count_o is unchanged;
  - err_o is set and stays set until start_i or rst_i;
  - if last_i=1, the DONE transition still happens.
- Full:
  - accepting at count_o = DEPTH-1 makes count_o = DEPTH and full_o = 1 on the next cycle, so ready_o drops;
  - count never exceeds DEPTH; addresses never wrap past BASE_ADDR+4*(DEPTH-1);
  - state stays RUN until start_i.
- done_o pulses in the same cycle as the final mem_we_o, or the cycle after the accept if the final kind was reserved.
- start_i concurrent with valid_i: start wins, no accept. A write from the previous cycle's accept still completes; the count is then cleared, and the clear overrides the increment.
- start_i while the state is already RUN restarts addressing at BASE_ADDR.

Test Plan:
- ADDR_W=8, BASE=0; start, then R-type rs=1 rt=2 rd=3 funct=0x20 -> one cycle later mem_we_o=1, addr=0x0, data=0x00221820, count_o=1.
- Next, addi rs=0 rt=8 imm=0x0005 back-to-back with nop -> data 0x20080005 @0x4, then 0x00000000 @0x8 on consecutive cycles; count_o=3.
- ADDR_W=2; start, 5 consecutive valid nops -> 4 writes @0x0..0xC, full_o=1 and ready_o=0 after the 4th, 5th never accepted, count_o=4.
- kind=11 accepted mid-stream -> no mem_we_o, count_o unchanged, err_o=1 held until next start_i clears it.
- addi with last_i=1 -> write plus done_o pulse same cycle, state DONE, ready_o=0; further valid ignored until start_i restarts at addr BASE.
- rst_i asserted the cycle after an accept -> no mem_we_o, all outputs 0, ready_o=0 until start_i; also start_i and valid_i together -> no accept, count_o=0.
